// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: DIGITS-wide decimal up/down counter with validated parallel load
// and a one-cycle terminal-count pulse on wrap, for cascading into the next stage's en.
module bcd_counter_ndigit #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err
);
    logic [4*DIGITS-1:0] count_q, count_d, inc_val, dec_val;
    logic                tc_q, tc_d, err_q, err_d;
    logic [DIGITS:0]     cy, bw;
    logic [DIGITS-1:0]   nib_ok;

    assign cy[0] = 1'b1;
    assign bw[0] = 1'b1;

    // Ripple carry/borrow: digit k moves only when all lower digits are at their limit
    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dig
            logic [3:0] d;
            assign d          = count_q[4*k +: 4];
            assign cy[k+1]    = cy[k] & (d == 4'd9);
            assign bw[k+1]    = bw[k] & (d == 4'd0);
            assign inc_val[4*k +: 4] = cy[k] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
            assign dec_val[4*k +: 4] = bw[k] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
            assign nib_ok[k]  = load_val[4*k +: 4] <= 4'd9;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = &nib_ok ? load_val : count_q;
            err_d   = ~&nib_ok;
        end else if (en) begin
            count_d = up_dn ? inc_val : dec_val;
            tc_d    = up_dn ? cy[DIGITS] : bw[DIGITS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign load_err = err_q;
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: directed and random stimulus against an integer-valued
// reference model of a 4-digit decimal counter.
module tb_bcd_counter_ndigit;
    localparam int D   = 4;
    localparam int W   = 4 * D;
    localparam int MAX = 9999;

    logic         clk = 1'b0;
    logic         reset = 1'b1, en = 1'b0, up_dn = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tc, load_err;

    int n_chk = 0, n_fail = 0;
    int val = 0;
    logic exp_tc = 1'b0, exp_err = 1'b0;

    bcd_counter_ndigit #(.DIGITS(D)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] b = '0;
        for (int i = 0; i < D; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] b);
        for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int s = 0, p = 1;
        for (int i = 0; i < D; i++) begin
            s += int'(b[4*i +: 4]) * p;
            p *= 10;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                        input logic e, input logic u);
        reset = r; load = l; load_val = lv; en = e; up_dn = u;
        @(posedge clk);
        exp_tc = 1'b0;
        exp_err = 1'b0;
        if (r) val = 0;
        else if (l) begin
            if (is_bcd(lv)) val = from_bcd(lv);
            else exp_err = 1'b1;
        end else if (e) begin
            if (u) begin
                exp_tc = (val == MAX);
                val = exp_tc ? 0 : val + 1;
            end else begin
                exp_tc = (val == 0);
                val = exp_tc ? MAX : val - 1;
            end
        end
        #1;
        chk("count", 32'(count), 32'(to_bcd(val)));
        chk("tc", 32'(tc), 32'(exp_tc));
        chk("load_err", 32'(load_err), 32'(exp_err));
    endtask

    initial begin
        step(1, 0, '0, 0, 0);
        step(1, 1, 16'h5555, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 1);
        step(0, 1, 16'h1299, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 1, 16'h12A4, 1, 1);
        step(0, 0, '0, 0, 1);
        step(0, 1, 16'h0999, 0, 0);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        step(0, 1, 16'h0000, 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 1, 16'h9998, 0, 0);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 1, 16'hF000, 0, 1);
        step(0, 1, 16'h0457, 0, 1);
        step(1, 1, 16'h8888, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            logic r, l, e, u;
            logic [W-1:0] lv;
            r  = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = (i % 400 < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 1) ? to_bcd($urandom_range(0, MAX)) : W'($urandom);
            step(r, l, lv, e, u);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
